// File: rtl/sensor_frontend.sv
// Sensor/button front end: synchronized, debounced, pulse-stretched buttons, a sample latch and a prescaled tick counter.
// Optional macro SENSOR_AVG_EN turns the sample latch into a 4-sample moving average.

module SensorDebounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic i_btn,
   output logic o_event
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} debState_t;

   logic r_sync1, r_sync2;
   debState_t r_state, w_nextState;
   logic [CW-1:0] r_cnt, w_nextCnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // The event fires only on the PRESS_WAIT->HELD transition, so a held button yields one event
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      o_event     = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_sync2) begin
               w_nextState = PRESS_WAIT;
               w_nextCnt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!r_sync2) begin
               w_nextState = IDLE;
            end else if (r_cnt == LAST) begin
               w_nextState = HELD;
               o_event     = 1'b1;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!r_sync2) begin
               w_nextState = RELEASE_WAIT;
               w_nextCnt   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (r_sync2) begin
               w_nextState = HELD;
            end else if (r_cnt == LAST) begin
               w_nextState = IDLE;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end
endmodule

module sensor_frontend #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 1024,
   parameter int TICK_DIV        = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] sensor_raw,
   input  logic        sensor_valid,
   input  logic        save_btn,
   input  logic        load_btn,
   output logic [31:0] sensor_input_to_save,
   output logic [31:0] save_signal,
   output logic [31:0] load_signal,
   output logic [31:0] counter
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic w_saveEvent, w_loadEvent, w_saveActive, w_loadAccept, w_sampleAccept;
   logic [HW-1:0] r_saveHold, r_loadHold;
   logic [PW-1:0] r_presc;
   logic [31:0] r_counter;
   logic [11:0] r_sample;

   SensorDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) saveDebounce (
      .clock(clock), .reset(reset), .i_btn(save_btn), .o_event(w_saveEvent)
   );
   SensorDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) loadDebounce (
      .clock(clock), .reset(reset), .i_btn(load_btn), .o_event(w_loadEvent)
   );

   assign w_saveActive   = (r_saveHold != '0);
   assign w_loadAccept   = w_loadEvent & ~w_saveEvent & ~w_saveActive;
   assign w_sampleAccept = sensor_valid & ~w_saveActive & ~w_saveEvent;

   // Save always wins: it retriggers its own hold and kills any pending load hold
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_saveHold <= '0;
         r_loadHold <= '0;
      end else begin
         if (w_saveEvent) r_saveHold <= HOLD_LOAD;
         else if (w_saveActive) r_saveHold <= r_saveHold - 1'b1;
         if (w_saveEvent) r_loadHold <= '0;
         else if (w_loadAccept) r_loadHold <= HOLD_LOAD;
         else if (r_loadHold != '0) r_loadHold <= r_loadHold - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_presc   <= '0;
         r_counter <= '0;
      end else if (w_saveEvent) begin
         r_presc   <= '0;
         r_counter <= '0;
      end else if (r_presc == PRESC_LAST) begin
         r_presc   <= '0;
         r_counter <= r_counter + 1'b1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

`ifdef SENSOR_AVG_EN
   logic [11:0] r_hist [3];
   logic [13:0] w_sum;
   assign w_sum = 14'(sensor_raw) + 14'(r_hist[0]) + 14'(r_hist[1]) + 14'(r_hist[2]);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hist[0] <= '0;
         r_hist[1] <= '0;
         r_hist[2] <= '0;
         r_sample  <= '0;
      end else if (w_sampleAccept) begin
         r_hist[0] <= sensor_raw;
         r_hist[1] <= r_hist[0];
         r_hist[2] <= r_hist[1];
         r_sample  <= 12'(w_sum >> 2);
      end
   end
`else
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_sample <= '0;
      else if (w_sampleAccept) r_sample <= sensor_raw;
   end
`endif

   assign sensor_input_to_save = {20'b0, r_sample};
   assign save_signal          = {31'b0, w_saveActive};
   assign load_signal          = {31'b0, (r_loadHold != '0)};
   assign counter              = r_counter;
endmodule

// File: tb/tb_sensor_frontend.sv
// Self-checking bench for sensor_frontend: run-length debounce model, hold/arbitration model and elapsed-time tick model.
// Honours SENSOR_AVG_EN when defined for the whole build.

module tb_sensor_frontend;
   localparam int D = 4;
   localparam int H = 8;
   localparam int T = 5;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [11:0] sensorRaw = '0;
   logic sensorValid = 1'b0;
   logic saveBtn = 1'b0;
   logic loadBtn = 1'b0;
   logic [31:0] sampleOut, saveSig, loadSig, tickCount;

   int errors = 0;
   int checks = 0;
   bit checkEn = 1'b0;

   bit mSaveHist [2];
   bit mLoadHist [2];
   bit mSavePressed, mLoadPressed;
   int mSaveRun, mLoadRun, mSaveLeft, mLoadLeft, mElapsed;
   logic [11:0] mSample;
`ifdef SENSOR_AVG_EN
   logic [11:0] mAvgHist [4];
`endif

   sensor_frontend #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .TICK_DIV(T)) dut (
      .clock(clock), .reset(reset), .sensor_raw(sensorRaw), .sensor_valid(sensorValid),
      .save_btn(saveBtn), .load_btn(loadBtn), .sensor_input_to_save(sampleOut),
      .save_signal(saveSig), .load_signal(loadSig), .counter(tickCount)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mSaveHist = '{0, 0};
      mLoadHist = '{0, 0};
      mSavePressed = 0; mLoadPressed = 0;
      mSaveRun = 0; mLoadRun = 0;
      mSaveLeft = 0; mLoadLeft = 0;
      mElapsed = 0;
      mSample = '0;
`ifdef SENSOR_AVG_EN
      for (int k = 0; k < 4; k++) mAvgHist[k] = '0;
`endif
   endtask

   // A debounced level flips after D+1 consecutive synchronized samples disagreeing with it
   task automatic debounceStep(input bit seen, inout bit pressed, inout int run, output bit ev);
      ev = 0;
      if (seen != pressed) begin
         run++;
         if (run == D + 1) begin
            pressed = seen;
            run = 0;
            ev = seen;
         end
      end else begin
         run = 0;
      end
   endtask

   task automatic modelStep();
      bit sSeen, lSeen, sEv, lEv, saveActive;
      int sum;
      sSeen = mSaveHist[1]; mSaveHist[1] = mSaveHist[0]; mSaveHist[0] = saveBtn;
      lSeen = mLoadHist[1]; mLoadHist[1] = mLoadHist[0]; mLoadHist[0] = loadBtn;
      debounceStep(sSeen, mSavePressed, mSaveRun, sEv);
      debounceStep(lSeen, mLoadPressed, mLoadRun, lEv);
      saveActive = (mSaveLeft > 0);
      if (sensorValid && !saveActive && !sEv) begin
`ifdef SENSOR_AVG_EN
         for (int k = 3; k > 0; k--) mAvgHist[k] = mAvgHist[k-1];
         mAvgHist[0] = sensorRaw;
         sum = 0;
         for (int k = 0; k < 4; k++) sum += int'(mAvgHist[k]);
         mSample = 12'(sum / 4);
`else
         sum = int'(sensorRaw);
         mSample = 12'(sum);
`endif
      end
      if (sEv) mLoadLeft = 0;
      else if (lEv && !saveActive) mLoadLeft = H;
      else if (mLoadLeft > 0) mLoadLeft--;
      if (sEv) mSaveLeft = H;
      else if (mSaveLeft > 0) mSaveLeft--;
      mElapsed = sEv ? 0 : mElapsed + 1;
   endtask

   // Called in the low clock phase; leaves the bench at the following negedge
   task automatic applyStimulus(input bit s, input bit l, input bit v, input logic [11:0] raw);
      saveBtn = s; loadBtn = l; sensorValid = v; sensorRaw = raw;
      @(posedge clock);
      modelStep();
      @(negedge clock);
   endtask

   task automatic doReset(input bit checkAsync);
      checkEn = 0;
      saveBtn = 0; loadBtn = 0; sensorValid = 0; sensorRaw = '0;
      #2 reset = 1;
      #1;
      if (checkAsync) begin
         checkOutput("rstSample", sampleOut, 32'd0);
         checkOutput("rstSave", saveSig, 32'd0);
         checkOutput("rstLoad", loadSig, 32'd0);
         checkOutput("rstCounter", tickCount, 32'd0);
      end
      modelReset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 0;
      checkEn = 1;
   endtask

   always @(negedge clock) begin
      if (checkEn && !reset) begin
         checkOutput("sample", sampleOut, {20'b0, mSample});
         checkOutput("save", saveSig, (mSaveLeft > 0) ? 32'd1 : 32'd0);
         checkOutput("load", loadSig, (mLoadLeft > 0) ? 32'd1 : 32'd0);
         checkOutput("counter", tickCount, 32'(mElapsed / T));
      end
   end

   initial begin
      int ones, rises;
      logic [31:0] prevLoad;
      bit sState, lState;
      int expStrobe [4];
      int strobeVal [4];
      strobeVal = '{4, 8, 12, 16};
`ifdef SENSOR_AVG_EN
      expStrobe = '{1, 3, 6, 10};
`else
      expStrobe = '{4, 8, 12, 16};
`endif
      modelReset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 0;
      checkOutput("resetSample", sampleOut, 32'd0);
      checkOutput("resetCounter", tickCount, 32'd0);
      checkEn = 1;

      repeat (20) applyStimulus(0, 0, 0, '0);
      checkOutput("idleCounter", tickCount, 32'd4);
      checkOutput("idleSave", saveSig, 32'd0);

      for (int i = 1; i <= 24; i++) begin
         applyStimulus(i <= 12, 0, 0, '0);
         if (i == 6) begin
            checkOutput("savePre", saveSig, 32'd0);
            checkOutput("counterPre", tickCount, 32'd5);
         end
         if (i == 7) begin
            checkOutput("saveRise", saveSig, 32'd1);
            checkOutput("counterClr", tickCount, 32'd0);
         end
         if (i == 14) checkOutput("saveLast", saveSig, 32'd1);
         if (i == 15) checkOutput("saveEnd", saveSig, 32'd0);
      end
      repeat (4) applyStimulus(0, 0, 0, '0);

      ones = 0;
      for (int i = 1; i <= 13; i++) begin
         applyStimulus(i <= 3, 0, 0, '0);
         if (loadSig == 32'd1) ones++;
      end
      checkOutput("loadGlitch", 32'(ones), 32'd0);
      ones = 0; rises = 0; prevLoad = '0;
      for (int i = 1; i <= 30; i++) begin
         applyStimulus(0, i <= 10, 0, '0);
         if (loadSig == 32'd1) ones++;
         if (loadSig == 32'd1 && prevLoad == 32'd0) rises++;
         prevLoad = loadSig;
      end
      checkOutput("loadWidth", 32'(ones), 32'd8);
      checkOutput("loadPulses", 32'(rises), 32'd1);

      ones = 0;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(i <= 8, i <= 8, 0, '0);
         if (i == 7) checkOutput("bothSave", saveSig, 32'd1);
         if (loadSig == 32'd1) ones++;
      end
      checkOutput("bothLoad", 32'(ones), 32'd0);
      repeat (6) applyStimulus(0, 0, 0, '0);

      ones = 0;
      for (int i = 1; i <= 24; i++) begin
         applyStimulus(i <= 10, i >= 5 && i <= 12, 0, '0);
         if (i == 11) checkOutput("blockSave", saveSig, 32'd1);
         if (loadSig == 32'd1) ones++;
      end
      checkOutput("loadIgnored", 32'(ones), 32'd0);
      repeat (6) applyStimulus(0, 0, 0, '0);

      for (int i = 1; i <= 24; i++) begin
         applyStimulus(i >= 3 && i <= 12, i <= 10, 0, '0);
         if (i == 8) checkOutput("cancelPre", loadSig, 32'd1);
         if (i == 9) begin
            checkOutput("cancelSave", saveSig, 32'd1);
            checkOutput("cancelLoad", loadSig, 32'd0);
         end
      end
      repeat (6) applyStimulus(0, 0, 0, '0);

      applyStimulus(0, 0, 1, 12'hABC);
`ifndef SENSOR_AVG_EN
      checkOutput("sampleABC", sampleOut, 32'h00000ABC);
`endif
      for (int i = 1; i <= 24; i++) begin
         applyStimulus(i <= 10, 0, i == 7 || i == 10, (i == 7) ? 12'h555 : 12'h123);
`ifndef SENSOR_AVG_EN
         if (i == 7 || i == 12) checkOutput("sampleFrozen", sampleOut, 32'h00000ABC);
`endif
      end
      applyStimulus(0, 0, 1, 12'h123);
`ifndef SENSOR_AVG_EN
      checkOutput("sample123", sampleOut, 32'h00000123);
`endif

      doReset(0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 1, 12'(strobeVal[k]));
         checkOutput("strobeSeq", sampleOut, 32'(expStrobe[k]));
      end

      for (int i = 1; i <= 9; i++) applyStimulus(1, 0, i == 2, 12'h7FF);
      checkOutput("midHoldSave", saveSig, 32'd1);
      doReset(1);
      repeat (8) applyStimulus(0, 0, 0, '0);
      checkOutput("postRstSave", saveSig, 32'd0);

      sState = 0; lState = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) sState = ~sState;
         if ($urandom_range(0, 9) == 0) lState = ~lState;
         applyStimulus(sState, lState, $urandom_range(0, 2) == 0, 12'($urandom));
      end

      checkEn = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
